// File: rtl/tap_thermo_encoder_pkg.sv
// Shared definitions for the tap thermometer encoder: FSM state encodings and
// the helper that sizes the fine code for a given tap count.
package tap_thermo_encoder_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ENCODE     = 2'd1;
    localparam logic [1:0] ST_WAIT_CLEAR = 2'd2;

    // Fine code must represent every count from 0 (no taps) to num (all taps).
    function automatic int fine_width(input int num);
        return $clog2(num + 1);
    endfunction

endpackage

// File: rtl/tap_thermo_encoder_popcount.sv
// Combinational thermometer decoder: ones count of the captured tap vector plus
// bubble (a 0 below some 1) and saturation (all ones) flags.
module thermo_popcount
    import tap_thermo_encoder_pkg::*;
#(
    parameter int NUM    = 12,
    parameter int FINE_W = fine_width(NUM)
) (
    input  logic [NUM-1:0]    vec,
    output logic [FINE_W-1:0] fine,
    output logic              bubble,
    output logic              sat
);

    logic seen_one;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        fine     = '0;
        bubble   = 1'b0;
        seen_one = 1'b0;
        // Scan from the far end of the chain: a 0 met after any 1 is a bubble.
        for (int i = NUM - 1; i >= 0; i--) begin
            fine = fine + FINE_W'(vec[i]);
            if (!vec[i] && seen_one) begin
                bubble = 1'b1;
            end
            if (vec[i]) begin
                seen_one = 1'b1;
            end
        end
    end

    assign sat = &vec;

endmodule

// File: rtl/tap_thermo_encoder.sv
// Samples the delay-chain taps, detects a new hit, encodes it and presents the
// time-stamped event downstream over a valid/ready output register.
module tap_thermo_encoder
    import tap_thermo_encoder_pkg::*;
#(
    parameter int NUM      = 12,
    parameter int FINE_W   = fine_width(NUM),
    parameter int COARSE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM-1:0]      taps,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FINE_W-1:0]   out_fine,
    output logic [COARSE_W-1:0] out_coarse,
    output logic                out_bubble,
    output logic                out_sat,
    output logic                overflow
);

    logic [NUM-1:0]      s1;
    logic [NUM-1:0]      s2;
    logic                s2_d0;
    logic [NUM-1:0]      snap;
    logic [COARSE_W-1:0] counter;
    logic [COARSE_W-1:0] coarse_snap;
    logic [1:0]          state;

    logic [FINE_W-1:0]   enc_fine;
    logic                enc_bubble;
    logic                enc_sat;
    logic                detect;

    thermo_popcount #(
        .NUM    (NUM),
        .FINE_W (FINE_W)
    ) u_popcount (
        .vec    (snap),
        .fine   (enc_fine),
        .bubble (enc_bubble),
        .sat    (enc_sat)
    );

    // Rising edge on the first tap after synchronisation marks a new hit.
    assign detect = s2[0] && !s2_d0;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, which keeps the sync chain a true two-stage
    // pipeline regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1          <= '0;
            s2          <= '0;
            s2_d0       <= 1'b0;
            snap        <= '0;
            counter     <= '0;
            coarse_snap <= '0;
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            out_fine    <= '0;
            out_coarse  <= '0;
            out_bubble  <= 1'b0;
            out_sat     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            s1      <= taps;
            s2      <= s1;
            s2_d0   <= s2[0];
            counter <= counter + COARSE_W'(1);

            // A completed transfer empties the output unless ENCODE refills it below.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (detect) begin
                        snap        <= s2;
                        coarse_snap <= counter;
                        state       <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    if (!out_valid || out_ready) begin
                        out_valid  <= 1'b1;
                        out_fine   <= enc_fine;
                        out_coarse <= coarse_snap;
                        out_bubble <= enc_bubble;
                        out_sat    <= enc_sat;
                    end else begin
                        overflow <= 1'b1;
                    end
                    state <= ST_WAIT_CLEAR;
                end
                ST_WAIT_CLEAR: begin
                    if (!s2[0]) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_thermo_encoder.sv
// Directed bench for tap_thermo_encoder: a NUM=12/COARSE_W=16 instance for the
// main behaviour and a COARSE_W=4 instance for counter wrap.
module tb_tap_thermo_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] taps;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_fine;
    logic [15:0] out_coarse;
    logic        out_bubble;
    logic        out_sat;
    logic        overflow;

    logic [11:0] taps4;
    logic        ready4;
    logic        valid4;
    logic [3:0]  fine4;
    logic [3:0]  coarse4;
    logic        bubble4;
    logic        sat4;
    logic        overflow4;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;   // non-reset edges since reset release = expected counter value

    always #5 clk = ~clk;

    tap_thermo_encoder #(.NUM(12), .COARSE_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .taps       (taps),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fine   (out_fine),
        .out_coarse (out_coarse),
        .out_bubble (out_bubble),
        .out_sat    (out_sat),
        .overflow   (overflow)
    );

    tap_thermo_encoder #(.NUM(12), .COARSE_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .taps       (taps4),
        .out_valid  (valid4),
        .out_ready  (ready4),
        .out_fine   (fine4),
        .out_coarse (coarse4),
        .out_bubble (bubble4),
        .out_sat    (sat4),
        .overflow   (overflow4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) cyc++;
        else     cyc = 0;
        #1;
    endtask

    // Applies a hit before E0 and returns just after E3; exp_coarse is the
    // counter value at the detection edge E2.
    task automatic hit(input logic [11:0] v, output int exp_coarse);
        taps = v;
        tick();   // E0
        tick();   // E1
        exp_coarse = cyc & 16'hFFFF;
        tick();   // E2
        check("no_valid_before_e3", out_valid, (v == 12'h01F) ? 1 : 0);
        tick();   // E3
    endtask

    task automatic clear_taps();
        taps = '0;
        repeat (4) tick();
    endtask

    int exp_c;
    int events;

    initial begin
        rst       = 1'b0;
        taps      = 12'hFFF;
        out_ready = 1'b1;
        taps4     = '0;
        ready4    = 1'b1;

        // 1. Reset with taps all ones, then release: the all-ones vector is a hit.
        repeat (3) tick();
        check("rst_valid",    out_valid,  0);
        check("rst_overflow", overflow,   0);
        check("rst_coarse",   out_coarse, 0);
        check("rst_fine",     out_fine,   0);
        rst = 1'b1;
        repeat (4) tick();
        check("rel_valid",  out_valid,  1);
        check("rel_coarse", out_coarse, 2);
        check("rel_fine",   out_fine,   12);
        check("rel_sat",    out_sat,    1);
        clear_taps();

        // 2. Plain thermometer code, one-cycle valid pulse.
        hit(12'h03F, exp_c);
        check("t2_valid",  out_valid,  1);
        check("t2_fine",   out_fine,   6);
        check("t2_bubble", out_bubble, 0);
        check("t2_sat",    out_sat,    0);
        check("t2_coarse", out_coarse, exp_c);
        tick();
        check("t2_valid_drop", out_valid, 0);
        clear_taps();

        // 3. Bubbled vector, then saturated vector.
        hit(12'h0F7, exp_c);
        check("t3_valid",  out_valid,  1);
        check("t3_fine",   out_fine,   7);
        check("t3_bubble", out_bubble, 1);
        check("t3_sat",    out_sat,    0);
        clear_taps();
        hit(12'hFFF, exp_c);
        check("t3s_fine",   out_fine,   12);
        check("t3s_sat",    out_sat,    1);
        check("t3s_bubble", out_bubble, 0);
        check("t3s_coarse", out_coarse, exp_c);
        clear_taps();

        // 4. Stalled output: second hit is dropped and flagged.
        out_ready = 1'b0;
        hit(12'h007, exp_c);
        check("t4a_valid", out_valid, 1);
        check("t4a_fine",  out_fine,  3);
        clear_taps();
        hit(12'h01F, events);
        tick();
        check("t4_hold_valid",  out_valid,  1);
        check("t4_hold_fine",   out_fine,   3);
        check("t4_hold_coarse", out_coarse, exp_c);
        check("t4_overflow",    overflow,   1);
        out_ready = 1'b1;
        tick();
        check("t4_accept_valid", out_valid, 0);
        check("t4_sticky_ovf",   overflow,  1);
        clear_taps();

        // 5. Long hit gives one event; a one-cycle low in s2 re-arms.
        events = 0;
        taps = 12'h001;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) events++;
        end
        check("t5_single_event", events, 1);
        taps = 12'h000;
        tick();
        taps = 12'h001;
        events = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) events++;
        end
        check("t5_rearm_event", events, 1);
        clear_taps();

        // 6. COARSE_W=4 wrap: detect at counter 15, then at counter 1.
        while ((cyc % 16) != 13) tick();
        taps4 = 12'h00F;
        repeat (4) tick();
        check("t6_valid_a",  valid4,  1);
        check("t6_coarse_a", coarse4, 15);
        check("t6_fine_a",   fine4,   4);
        taps4 = '0;
        repeat (4) tick();
        while ((cyc % 16) != 15) tick();
        taps4 = 12'h003;
        repeat (4) tick();
        check("t6_valid_b",  valid4,  1);
        check("t6_coarse_b", coarse4, 1);
        taps4 = '0;
        repeat (4) tick();

        // Reset while in ENCODE discards the in-flight event.
        taps4 = 12'h001;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("t6_rst_valid4",    valid4,    0);
        check("t6_rst_overflow4", overflow4, 0);
        check("t6_rst_overflow",  overflow,  0);
        rst = 1'b1;
        repeat (3) tick();
        check("t6_after_rst_valid4", valid4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
